// File: rtl/hvac_actuator_seq.sv
// hvac_actuator_seq
// Sequences the fan, heater and compressor relays from the controller's
// heat/cool demand bits. Enforces fan lead/lag, minimum run time and a
// compressor anti-short-cycle off-timer. Flags simultaneous heat+cool demand.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   heat_req        heating demand
//   cool_req        cooling demand
//   fan_on          fan relay
//   heater_on       heater relay
//   compressor_on   compressor relay
//   lockout         compressor off-timer still running
//   req_err         registered flag: heat_req & cool_req seen last cycle
//
// All outputs are decoded from registered state, so none of them depends
// combinationally on the inputs.
module hvac_actuator_seq #(
  parameter int CNT_W    = 8,
  parameter int FAN_LEAD = 2,
  parameter int FAN_LAG  = 3,
  parameter int MIN_ON   = 4,
  parameter int MIN_OFF  = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic heat_req,
  input  logic cool_req,
  output logic fan_on,
  output logic heater_on,
  output logic compressor_on,
  output logic lockout,
  output logic req_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FAN_PRE  = 3'd1,
    HEATING  = 3'd2,
    COOLING  = 3'd3,
    FAN_POST = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(FAN_LEAD - 1);
  localparam logic [CNT_W-1:0] LAG_LD  = CNT_W'(FAN_LAG - 1);
  localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(MIN_OFF);

  state_t           state, state_nxt;
  logic             mode_cool, mode_cool_nxt;  // mode held through FAN_PRE
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] off_tmr, off_tmr_nxt;

  logic hr, cr, lock;

  // Contradictory demand is treated as no demand at all.
  assign hr   = heat_req & ~cool_req;
  assign cr   = cool_req & ~heat_req;
  assign lock = (off_tmr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_cool <= 1'b0;
      cnt       <= '0;
      off_tmr   <= OFF_LD;
      req_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_cool <= mode_cool_nxt;
      cnt       <= cnt_nxt;
      off_tmr   <= off_tmr_nxt;
      req_err   <= heat_req & cool_req;
    end
  end

  always_comb begin
    state_nxt     = state;
    mode_cool_nxt = mode_cool;
    cnt_nxt       = cnt;
    case (state)
      IDLE: begin
        if (hr) begin
          state_nxt     = FAN_PRE;
          mode_cool_nxt = 1'b0;
          cnt_nxt       = LEAD_LD;
        end else if (cr && !lock) begin
          state_nxt     = FAN_PRE;
          mode_cool_nxt = 1'b1;
          cnt_nxt       = LEAD_LD;
        end
      end
      FAN_PRE: begin
        if (mode_cool ? !cr : !hr) begin
          state_nxt = FAN_POST;
          cnt_nxt   = LAG_LD;
        end else if (cnt == '0) begin
          state_nxt = mode_cool ? COOLING : HEATING;
          cnt_nxt   = ON_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HEATING, COOLING: begin
        // Counter holds at zero once the minimum run time is served.
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (state == HEATING ? !hr : !cr) begin
          state_nxt = FAN_POST;
          cnt_nxt   = LAG_LD;
        end
      end
      FAN_POST: begin
        // Demand returning during the lag skips the lead phase.
        if (hr) begin
          state_nxt = HEATING;
          cnt_nxt   = ON_LD;
        end else if (cr && !lock) begin
          state_nxt = COOLING;
          cnt_nxt   = ON_LD;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Anti-short-cycle timer restarts on the edge that leaves COOLING.
  always_comb begin
    off_tmr_nxt = off_tmr;
    if (state == COOLING && state_nxt != COOLING) off_tmr_nxt = OFF_LD;
    else if (lock)                                 off_tmr_nxt = off_tmr - 1'b1;
  end

  assign fan_on        = (state != IDLE);
  assign heater_on     = (state == HEATING);
  assign compressor_on = (state == COOLING);
  assign lockout       = lock;

endmodule

// File: tb/tb_hvac_actuator_seq.sv
// Testbench for hvac_actuator_seq: directed scenarios followed by random
// demand traffic, every cycle compared against a relay-level reference model.
module tb_hvac_actuator_seq;
  localparam int FAN_LEAD = 2;
  localparam int FAN_LAG  = 3;
  localparam int MIN_ON   = 4;
  localparam int MIN_OFF  = 6;

  logic clk = 1'b0;
  logic rst_n, heat_req, cool_req;
  logic fan_on, heater_on, compressor_on, lockout, req_err;

  int tests = 0;
  int fails = 0;

  hvac_actuator_seq #(.CNT_W(8), .FAN_LEAD(FAN_LEAD), .FAN_LAG(FAN_LAG),
                      .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF)) dut (
    .clk(clk), .rst_n(rst_n), .heat_req(heat_req), .cool_req(cool_req),
    .fan_on(fan_on), .heater_on(heater_on), .compressor_on(compressor_on),
    .lockout(lockout), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Reference model: relay booleans plus elapsed-time counters per phase.
  bit m_fan, m_heat, m_comp, m_lag, m_cool, m_err;
  int m_t, m_off;

  task automatic model_step(input bit rst, input bit h, input bit c);
    bit hr, cr, lk, leave, want;
    if (!rst) begin
      m_fan = 0; m_heat = 0; m_comp = 0; m_lag = 0; m_cool = 0; m_err = 0;
      m_t = 0; m_off = MIN_OFF;
      return;
    end
    hr = h & !c; cr = c & !h; lk = (m_off != 0); leave = 0; m_err = h & c;
    if (!m_fan) begin
      if (hr)            begin m_fan = 1; m_cool = 0; m_t = 0; m_lag = 0; end
      else if (cr && !lk) begin m_fan = 1; m_cool = 1; m_t = 0; m_lag = 0; end
    end else if (m_heat || m_comp) begin
      want = m_comp ? cr : hr;
      if (m_t + 1 >= MIN_ON && !want) begin
        leave = m_comp; m_heat = 0; m_comp = 0; m_lag = 1; m_t = 0;
      end else m_t++;
    end else if (m_lag) begin
      if (hr)             begin m_heat = 1; m_lag = 0; m_t = 0; end
      else if (cr && !lk) begin m_comp = 1; m_lag = 0; m_t = 0; end
      else if (m_t + 1 >= FAN_LAG) m_fan = 0;
      else m_t++;
    end else begin
      if (!(m_cool ? cr : hr)) begin m_lag = 1; m_t = 0; end
      else if (m_t + 1 >= FAN_LEAD) begin
        m_heat = !m_cool; m_comp = m_cool; m_t = 0;
      end else m_t++;
    end
    m_off = leave ? MIN_OFF : (m_off > 0 ? m_off - 1 : 0);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive on negedge, model the rising edge, sample 1 unit later.
  task automatic cyc(input bit r, input bit h, input bit c);
    @(negedge clk);
    rst_n = r; heat_req = h; cool_req = c;
    @(posedge clk);
    model_step(r, h, c);
    #1;
    chk("fan_on", fan_on, m_fan);
    chk("heater_on", heater_on, m_heat);
    chk("compressor_on", compressor_on, m_comp);
    chk("lockout", lockout, m_off != 0);
    chk("req_err", req_err, m_err);
    chk("relay_excl", heater_on & compressor_on, 1'b0);
  endtask

  task automatic run(input int n, input bit r, input bit h, input bit c);
    for (int i = 0; i < n; i++) cyc(r, h, c);
  endtask

  initial begin
    bit h, c, r;
    rst_n = 0; heat_req = 0; cool_req = 0;
    run(2, 0, 0, 0);
    // Reset state, spelled out as constants.
    chk("rst_fan", fan_on, 1'b0);
    chk("rst_lockout", lockout, 1'b1);
    chk("rst_err", req_err, 1'b0);

    // Release with cool held: waits out lockout then full lead.
    run(6, 1, 0, 1);
    chk("lock_still", lockout, 1'b0);
    chk("lock_fan_off", fan_on, 1'b0);
    cyc(1, 0, 1);
    chk("cool_fan_up", fan_on, 1'b1);
    run(2, 1, 0, 1);
    chk("cool_comp_up", compressor_on, 1'b1);
    // Drop cool after min on, reassert in FAN_POST: locked out.
    run(4, 1, 0, 0);
    chk("post_lag", fan_on & lockout, 1'b1);
    run(12, 1, 0, 1);
    run(6, 1, 0, 0);

    // heat pulse of one cycle from IDLE.
    cyc(1, 1, 0);
    chk("pulse_fan", fan_on, 1'b1);
    run(5, 1, 0, 0);
    chk("pulse_idle", fan_on, 1'b0);

    // heat held 10 cycles, then a 3-cycle heat run for min on.
    run(10, 1, 1, 0);
    run(5, 1, 0, 0);
    run(3, 1, 1, 0);
    run(7, 1, 0, 0);

    // Illegal demand in IDLE, then during HEATING.
    run(3, 1, 1, 1);
    run(2, 1, 0, 0);
    run(8, 1, 1, 0);
    run(2, 1, 1, 1);
    chk("illegal_post", heater_on, 1'b0);
    run(5, 1, 0, 0);

    // Reset during COOLING.
    run(20, 1, 0, 1);
    chk("pre_rst_comp", compressor_on, 1'b1);
    cyc(0, 0, 1);
    chk("rst_mid_fan", fan_on, 1'b0);
    run(8, 1, 0, 0);

    // Random traffic with held demands and rare resets.
    h = 0; c = 0; r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) h = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 1);
      r = ($urandom_range(0, 299) != 0);
      cyc(r, h, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hvac_actuator_seq.md
Name: hvac_actuator_seq

Overview:
- Downstream stage of the air-conditioning controller.
- Consumes the controller's registered heat/cool demand bits and sequences the physical actuators: fan, heater element and compressor.
- Enforces fan lead/lag times, a minimum run time and a compressor anti-short-cycle lockout.
- Flags illegal simultaneous demands.
- Outputs drive the relay/actuator pins directly.

Parameters:
- CNT_W, 8: width of all internal timers; every time parameter must be ≤ 2^CNT_W−1.
- FAN_LEAD, 2: cycles the fan runs before the heater or compressor energises (≥1).
- FAN_LAG, 3: cycles the fan keeps running after the heater or compressor de-energises (≥1).
- MIN_ON, 4: minimum consecutive cycles the heater or compressor stays on once started (≥1).
- MIN_OFF, 6: compressor off-timer reload value (anti-short-cycle), also applied at reset (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- heat_req  in  1  heating demand from the AC controller.
- cool_req  in  1  cooling demand from the AC controller.
- fan_on  out  1  fan relay.
- heater_on  out  1  heater relay.
- compressor_on  out  1  compressor relay.
- lockout  out  1  high while the compressor off-timer is non-zero.
- req_err  out  1  registered; high for one cycle per sampled cycle with heat_req & cool_req both high.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, all relays 0, req_err=0, run counter 0.
  - Off-timer loaded with MIN_OFF, so lockout=1 immediately after reset.
- Decode: all outputs are Moore outputs decoded from registered state/counters. Nothing is combinational from the inputs.
- Effective requests: hr = heat_req & ~cool_req; cr = cool_req & ~heat_req. Both high counts as no request, and req_err=1 on the following cycle.
- Off-timer:
  - Loaded with MIN_OFF on the edge that leaves COOLING.
  - Otherwise decrements by 1 each edge while non-zero; saturates at 0.
  - lockout = (off-timer != 0).
- States and transitions, evaluated each edge:
  - IDLE: relays 0.
    - hr → FAN_PRE (mode=HEAT, cnt=FAN_LEAD−1).
    - cr & ~lockout → FAN_PRE (mode=COOL, cnt=FAN_LEAD−1).
    - cr & lockout → stay IDLE (request pends, not latched).
  - FAN_PRE: fan_on=1.
    - Request for the current mode dropped → FAN_POST (cnt=FAN_LAG−1).
    - Else cnt==0 → HEATING or COOLING with cnt=MIN_ON−1.
    - Else cnt−1.
  - HEATING: fan_on=1, heater_on=1.
    - cnt decrements to 0 and holds.
    - Exit to FAN_POST (cnt=FAN_LAG−1) only when cnt==0 & ~hr.
  - COOLING: fan_on=1, compressor_on=1.
    - Same as HEATING, using cr.
    - Exit also reloads the off-timer.
  - FAN_POST: fan_on=1.
    - hr → HEATING directly (cnt=MIN_ON−1, no lead).
    - cr & ~lockout → COOLING directly.
    - Else cnt==0 → IDLE.
    - Else cnt−1.
- Mode switch: heat→cool or cool→heat always passes through FAN_POST. Direct HEATING↔COOLING is never taken.
- Illegal demand during a run counts as the demand dropping, but MIN_ON is still honoured.
- heater_on and compressor_on are never simultaneously 1 (invariant).
- Timing from the edge that samples a request, with state IDLE and lockout=0:
  - fan_on=1 after edge k.
  - heater_on or compressor_on=1 after edge k+FAN_LEAD.
- Minimum compressor off time: re-entry to COOLING is possible no earlier than MIN_OFF+1 edges after the exit edge.
- Reset mid-run: relays drop after the reset edge, with no lag phase. The off-timer reloads.

Test Plan (FAN_LEAD=2, FAN_LAG=3, MIN_ON=4, MIN_OFF=6):
- Reset release, cool_req=1 held → lockout=1 for 6 cycles. Compressor and fan stay 0 until the off-timer reaches 0. fan_on rises the cycle after, and compressor_on rises 2 cycles later.
- heat_req pulse 1 cycle from IDLE → fan_on high after edge k. Request drops → FAN_POST. Fan stays on 3 further cycles then IDLE; heater_on never asserts.
- heat_req held 10 cycles → heater_on after edge k+2. heater_on stays until the cycle after heat_req falls, then fan runs 3 more cycles. heat_req held only 1 cycle past heater start → heater still on ≥4 cycles.
- Cool run ends, cool_req reasserted during FAN_POST → no direct re-entry (lockout=1). Returns to IDLE, waits out the off-timer, then does a full FAN_PRE. Compressor off for ≥7 cycles.
- heat_req=cool_req=1 for 3 cycles in IDLE → req_err high 3 cycles, relays all 0. Same while HEATING (cnt==0) → heater drops, FAN_POST entered.
- rst_n=0 during COOLING → all relays 0 after that edge; lockout=1 for 6 cycles after release.
